// File: rtl/keypad_scanner_if.sv
// Calculator entry strobes produced by the keypad scanner.
interface keypad_scanner_if;
   logic       is_num;
   logic [3:0] num_val;
   logic       is_op1;
   logic       is_op2;
   logic [3:0] op_val;
   logic       save;
   logic       clr;
   logic       key_valid;
   logic [3:0] key_code;

   modport master (
      output is_num, num_val, is_op1, is_op2, op_val, save, clr, key_valid, key_code
   );

   modport slave (
      input is_num, num_val, is_op1, is_op2, op_val, save, clr, key_valid, key_code
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with sweep-level debounce and calculator
// entry-phase sequencing.
//
// state | meaning
// ------+---------------------------------------------
// OP1   | entering operand 1 (digits, then C/D operator)
// OP2   | entering operand 2 (digits, C/D re-select, E = result)
// RES   | result shown; next digit restarts at OP1
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_SWEEPS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   keypad_scanner_if.master kp
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SWEEPS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SWEEPS);

   typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} sweep_t;
   typedef enum logic [1:0] {OP1, OP2, RES} phase_t;

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic [1:0]       col_nxt;
   logic [3:0]       row_s1, row_s2;
   logic [1:0]       hit_cnt;
   logic [3:0]       hit_code;
   logic             col_end, sweep_end;

   logic [1:0]       col_hits;
   logic [1:0]       col_row;
   logic [2:0]       hit_sum;
   logic [1:0]       sweep_hits;
   logic [3:0]       sweep_code;
   sweep_t           sweep_kind, prev_kind;
   logic [3:0]       prev_code;
   logic [CNT_W-1:0] stable_cnt, cnt_nxt;
   logic             reported, same, accept;
   phase_t           state;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;
         4'h1: return 4'h2;
         4'h2: return 4'h3;
         4'h3: return 4'hA;
         4'h4: return 4'h4;
         4'h5: return 4'h5;
         4'h6: return 4'h6;
         4'h7: return 4'hB;
         4'h8: return 4'h7;
         4'h9: return 4'h8;
         4'hA: return 4'h9;
         4'hB: return 4'hC;
         4'hC: return 4'hF;
         4'hD: return 4'h0;
         4'hE: return 4'hE;
         default: return 4'hD;
      endcase
   endfunction

   assign col_end   = (div_cnt == DIV_LAST);
   assign sweep_end = col_end && (col_idx == 2'd3);
   assign col_nxt   = col_idx + 2'd1;

   // Count active rows in the column being sampled and fold into the sweep result.
   always_comb begin
      col_hits = 2'd0;
      col_row  = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2[r]) begin
            col_row  = 2'(r);
            col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
         end
      end
      hit_sum    = {1'b0, hit_cnt} + {1'b0, col_hits};
      sweep_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      sweep_code = (col_hits == 2'd1) ? key_map(col_row, col_idx) : hit_code;
      case (sweep_hits)
         2'd0:    sweep_kind = RES_NONE;
         2'd1:    sweep_kind = RES_KEY;
         default: sweep_kind = RES_MULTI;
      endcase
      same    = (sweep_kind == prev_kind) && ((sweep_kind != RES_KEY) || (sweep_code == prev_code));
      cnt_nxt = !same ? CNT_W'(1) : ((stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1));
      accept  = sweep_end && (cnt_nxt == CNT_MAX) && (sweep_kind == RES_KEY) && !reported;
   end

   // Column drive, row synchronizer and per-sweep hit accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         col_idx  <= 2'd0;
         col      <= 4'b1110;
         row_s1   <= 4'hF;
         row_s2   <= 4'hF;
         hit_cnt  <= 2'd0;
         hit_code <= 4'h0;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
         if (col_end) begin
            div_cnt <= '0;
            col_idx <= col_nxt;
            col     <= ~(4'b0001 << col_nxt);
            if (sweep_end) begin
               hit_cnt  <= 2'd0;
               hit_code <= 4'h0;
            end else begin
               hit_cnt  <= sweep_hits;
               hit_code <= sweep_code;
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   // Sweep-to-sweep debounce; reported blocks repeats until a stable release.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_kind  <= RES_NONE;
         prev_code  <= 4'h0;
         stable_cnt <= '0;
         reported   <= 1'b0;
      end else if (sweep_end) begin
         prev_kind  <= sweep_kind;
         prev_code  <= sweep_code;
         stable_cnt <= cnt_nxt;
         if (cnt_nxt == CNT_MAX)
            reported <= (sweep_kind == RES_KEY);
      end
   end

   // Entry-phase FSM; all strobes and held values are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= OP1;
         kp.is_op1    <= 1'b1;
         kp.is_op2    <= 1'b0;
         kp.is_num    <= 1'b0;
         kp.save      <= 1'b0;
         kp.clr       <= 1'b0;
         kp.key_valid <= 1'b0;
         kp.num_val   <= 4'h0;
         kp.op_val    <= 4'hD;
         kp.key_code  <= 4'h0;
      end else begin
         kp.is_num    <= 1'b0;
         kp.save      <= 1'b0;
         kp.clr       <= 1'b0;
         kp.key_valid <= 1'b0;
         if (accept) begin
            kp.key_valid <= 1'b1;
            kp.key_code  <= sweep_code;
            if (sweep_code == 4'hF) begin
               kp.clr    <= 1'b1;
               kp.op_val <= 4'hD;
               state     <= OP1;
               kp.is_op1 <= 1'b1;
               kp.is_op2 <= 1'b0;
            end else begin
               case (state)
                  OP1: begin
                     if (sweep_code <= 4'd9) begin
                        kp.is_num  <= 1'b1;
                        kp.num_val <= sweep_code;
                     end else if (sweep_code == 4'hC || sweep_code == 4'hD) begin
                        kp.op_val <= sweep_code;
                        state     <= OP2;
                        kp.is_op1 <= 1'b0;
                        kp.is_op2 <= 1'b1;
                     end
                  end
                  OP2: begin
                     if (sweep_code <= 4'd9) begin
                        kp.is_num  <= 1'b1;
                        kp.num_val <= sweep_code;
                     end else if (sweep_code == 4'hC || sweep_code == 4'hD) begin
                        kp.op_val <= sweep_code;
                     end else if (sweep_code == 4'hE) begin
                        kp.save   <= 1'b1;
                        state     <= RES;
                        kp.is_op2 <= 1'b0;
                     end
                  end
                  default: begin
                     if (sweep_code <= 4'd9) begin
                        state     <= OP1;
                        kp.is_op1 <= 1'b1;
                     end
                  end
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: cycle-level reference model plus
// directed entry sequences and corner cases.
module tb_keypad_scanner;
   localparam int SD  = 4;
   localparam int DEB = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] pressed = 16'h0;

   keypad_scanner_if kp ();

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SWEEPS(DEB)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col), .kp(kp)
   );

   always #5 clk = ~clk;

   // Keypad matrix: key (r,c) at pressed[r*4+c] pulls row r low while column c is driven.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         if ((pressed[r*4 +: 4] & ~col) != 4'h0) row[r] = 1'b0;
   end

   int total = 0;
   int bad   = 0;

   logic [3:0] keymap [16];

   // reference model state
   int          m_n;
   logic [15:0] ph0, ph1, ph2;
   int          m_hits;
   logic [3:0]  m_code;
   int          m_prev_kind;
   logic [3:0]  m_prev_code;
   int          m_cnt;
   bit          m_rep;
   int          m_phase;
   logic        e_is_num, e_save, e_clr, e_kv, e_op1, e_op2;
   logic [3:0]  e_num_val, e_op_val, e_kc;

   // observations for directed checks
   int n_num, n_save, n_clr, n_kv, obs_cyc, obs_first;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_hits = 0; m_code = 4'h0;
      m_prev_kind = 0; m_prev_code = 4'h0; m_cnt = 0; m_rep = 1'b0; m_phase = 0;
      e_is_num = 0; e_save = 0; e_clr = 0; e_kv = 0;
      e_op1 = 1; e_op2 = 0; e_num_val = 4'h0; e_op_val = 4'hD; e_kc = 4'h0;
   endtask

   task automatic apply_key(input logic [3:0] k);
      e_kv = 1'b1;
      e_kc = k;
      if (k == 4'hF) begin
         e_clr = 1'b1; m_phase = 0; e_op_val = 4'hD;
      end else if (m_phase == 0) begin
         if (k <= 4'd9) begin e_is_num = 1'b1; e_num_val = k; end
         else if (k == 4'hC || k == 4'hD) begin e_op_val = k; m_phase = 1; end
      end else if (m_phase == 1) begin
         if (k <= 4'd9) begin e_is_num = 1'b1; e_num_val = k; end
         else if (k == 4'hC || k == 4'hD) e_op_val = k;
         else if (k == 4'hE) begin e_save = 1'b1; m_phase = 2; end
      end else begin
         if (k <= 4'd9) m_phase = 0;
      end
      e_op1 = (m_phase == 0);
      e_op2 = (m_phase == 1);
   endtask

   // Advance the model over cycle m_n using the current key mask.
   task automatic model_cycle();
      int kind;
      bit same;
      ph2 = ph1; ph1 = ph0; ph0 = pressed;
      e_is_num = 0; e_save = 0; e_clr = 0; e_kv = 0;
      if (m_n % SD == SD - 1) begin
         int c;
         c = (m_n / SD) % 4;
         for (int r = 0; r < 4; r++)
            if (ph2[r*4 + c]) begin m_hits++; m_code = keymap[r*4 + c]; end
      end
      if (m_n % (4*SD) == 4*SD - 1) begin
         kind = (m_hits == 0) ? 0 : (m_hits == 1) ? 1 : 2;
         same = (kind == m_prev_kind) && (kind != 1 || m_code == m_prev_code);
         m_cnt = same ? ((m_cnt + 1 > DEB) ? DEB : m_cnt + 1) : 1;
         m_prev_kind = kind;
         m_prev_code = m_code;
         if (m_cnt == DEB) begin
            if (kind == 1 && !m_rep) begin m_rep = 1'b1; apply_key(m_code); end
            else if (kind != 1) m_rep = 1'b0;
         end
         m_hits = 0;
      end
      m_n++;
   endtask

   task automatic model_check();
      logic [3:0]  one;
      logic [3:0]  e_col;
      logic [21:0] act, exp;
      one   = 4'b0001;
      e_col = ~(one << ((m_n / SD) % 4));
      act = {col, kp.is_num, kp.num_val, kp.is_op1, kp.is_op2, kp.op_val,
             kp.save, kp.clr, kp.key_valid, kp.key_code};
      exp = {e_col, e_is_num, e_num_val, e_op1, e_op2, e_op_val, e_save, e_clr, e_kv, e_kc};
      chk("model", 32'(act), 32'(exp));
   endtask

   task automatic clr_obs();
      n_num = 0; n_save = 0; n_clr = 0; n_kv = 0; obs_cyc = 0; obs_first = -1;
   endtask

   task automatic step(input logic [15:0] p);
      @(posedge clk); #1;
      obs_cyc++;
      model_check();
      if (kp.is_num) begin n_num++; if (obs_first < 0) obs_first = obs_cyc; end
      if (kp.save) n_save++;
      if (kp.clr) n_clr++;
      if (kp.key_valid) n_kv++;
      pressed = p;
      model_cycle();
   endtask

   task automatic hold(input logic [15:0] p, input int n);
      repeat (n) step(p);
   endtask

   task automatic do_reset(input logic [15:0] p);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      model_check();
      pressed = p;
      model_cycle();
   endtask

   typedef struct {
      int         idx;
      int         n_num;
      int         n_save;
      int         n_clr;
      logic [3:0] nv;
      logic [3:0] op;
      logic       op1;
      logic       op2;
      logic [3:0] kc;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [3:0] col_exp [4];
      keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};
      col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      ph0 = 16'h0; ph1 = 16'h0; ph2 = 16'h0;

      // key, is_num count, save count, clr count, num_val, op_val, is_op1, is_op2, key_code
      vecs[0]  = '{0,  1, 0, 0, 4'h1, 4'hD, 1'b1, 1'b0, 4'h1};
      vecs[1]  = '{1,  1, 0, 0, 4'h2, 4'hD, 1'b1, 1'b0, 4'h2};
      vecs[2]  = '{11, 0, 0, 0, 4'h2, 4'hC, 1'b0, 1'b1, 4'hC};
      vecs[3]  = '{2,  1, 0, 0, 4'h3, 4'hC, 1'b0, 1'b1, 4'h3};
      vecs[4]  = '{14, 0, 1, 0, 4'h3, 4'hC, 1'b0, 1'b0, 4'hE};
      vecs[5]  = '{8,  0, 0, 0, 4'h3, 4'hC, 1'b1, 1'b0, 4'h7};
      vecs[6]  = '{3,  0, 0, 0, 4'h3, 4'hC, 1'b1, 1'b0, 4'hA};
      vecs[7]  = '{15, 0, 0, 0, 4'h3, 4'hD, 1'b0, 1'b1, 4'hD};
      vecs[8]  = '{11, 0, 0, 0, 4'h3, 4'hC, 1'b0, 1'b1, 4'hC};
      vecs[9]  = '{7,  0, 0, 0, 4'h3, 4'hC, 1'b0, 1'b1, 4'hB};
      vecs[10] = '{12, 0, 0, 1, 4'h3, 4'hD, 1'b1, 1'b0, 4'hF};

      clr_obs();
      do_reset(16'h0);
      chk("rst_col", 32'(col), 32'(4'b1110));
      chk("rst_op1", 32'(kp.is_op1), 1);
      chk("rst_op2", 32'(kp.is_op2), 0);
      chk("rst_op_val", 32'(kp.op_val), 32'hD);
      chk("rst_num_val", 32'(kp.num_val), 0);
      chk("rst_key_code", 32'(kp.key_code), 0);

      // column rotation, one window every SD cycles
      for (int i = 1; i <= 16; i++) begin
         step(16'h0);
         if (i % 4 == 0) chk("col_rot", 32'(col), 32'(col_exp[(i / 4) % 4]));
      end

      clr_obs();
      hold(16'h0, 200);
      chk("idle_pulses", 32'(n_num + n_save + n_clr + n_kv), 0);

      // '7' held then released, latency bound, then re-press
      clr_obs();
      hold(16'h0100, 100);
      hold(16'h0, 60);
      chk("key7_count", 32'(n_num), 1);
      chk("key7_val", 32'(kp.num_val), 7);
      chk("key7_latency", 32'(obs_first >= 1 && obs_first - 1 <= 51), 1);
      clr_obs();
      hold(16'h0100, 100);
      hold(16'h0, 60);
      chk("key7_repress", 32'(n_num), 1);

      // bouncing '5' then settled
      clr_obs();
      for (int i = 0; i < 40; i++) step(((i / 3) % 2 == 0) ? 16'h0020 : 16'h0);
      hold(16'h0020, 80);
      hold(16'h0, 60);
      chk("bounce_count", 32'(n_num), 1);
      chk("bounce_val", 32'(kp.num_val), 5);

      // two keys in one row, then one released
      clr_obs();
      hold(16'h0003, 100);
      chk("multi_none", 32'(n_kv), 0);
      hold(16'h0001, 60);
      hold(16'h0, 60);
      chk("multi_to_1", 32'(n_num), 1);
      chk("multi_val", 32'(kp.num_val), 1);

      // entry sequence table
      for (int v = 0; v < 11; v++) begin
         clr_obs();
         hold(16'h1 << vecs[v].idx, 60);
         hold(16'h0, 60);
         chk($sformatf("vec%0d_num", v), 32'(n_num), 32'(vecs[v].n_num));
         chk($sformatf("vec%0d_save", v), 32'(n_save), 32'(vecs[v].n_save));
         chk($sformatf("vec%0d_clr", v), 32'(n_clr), 32'(vecs[v].n_clr));
         chk($sformatf("vec%0d_kv", v), 32'(n_kv), 1);
         chk($sformatf("vec%0d_state", v),
             32'({kp.num_val, kp.op_val, kp.is_op1, kp.is_op2, kp.key_code}),
             32'({vecs[v].nv, vecs[v].op, vecs[v].op1, vecs[v].op2, vecs[v].kc}));
      end

      // reset mid-sweep with '9' held
      hold(16'h0400, 21);
      do_reset(16'h0400);
      chk("mid_rst_col", 32'(col), 32'(4'b1110));
      chk("mid_rst_phase", 32'({kp.is_op1, kp.is_op2}), 32'(2'b10));
      chk("mid_rst_vals", 32'({kp.num_val, kp.op_val, kp.key_code}), 32'({4'h0, 4'hD, 4'h0}));
      clr_obs();
      hold(16'h0400, 60);
      hold(16'h0, 60);
      chk("post_rst_9_count", 32'(n_num), 1);
      chk("post_rst_9_val", 32'(kp.num_val), 9);

      // random presses against the model
      for (int it = 0; it < 40; it++) begin
         logic [15:0] m;
         m = 16'h1 << $urandom_range(0, 15);
         if ($urandom_range(0, 4) == 0) m = m | (16'h1 << $urandom_range(0, 15));
         hold(m, $urandom_range(0, 70));
         hold(16'h0, $urandom_range(0, 70));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces it, and turns each new key press into the calculator entry strobes consumed by the calculator top: `is_num`, `num_val`, `is_op1`, `is_op2`, `op_val`, `save`. It sits directly upstream of the calculator top and owns the entry phase: operand 1, operand 2, result.

## Interface

Parameters:
- `SCAN_DIV`, 1000: clock cycles each column is driven. Minimum 4.
- `DEBOUNCE_SWEEPS`, 4: consecutive identical full sweeps required before a key (or release) counts as stable. Minimum 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high.
- `row`  in  4  keypad rows, active-low, asynchronous. Synchronized internally with 2 flops.
- `col`  out  4  column drive, active-low one-hot.
- `is_num`  out  1  one-cycle pulse: a digit was pressed.
- `num_val`  out  4  last digit, 0-9; held between pulses.
- `is_op1`  out  1  level: operand 1 entry phase.
- `is_op2`  out  1  level: operand 2 entry phase.
- `op_val`  out  4  selected operator code, held. 4'hD = add, 4'hC = subtract.
- `save`  out  1  one-cycle pulse: result requested ('=').
- `clr`  out  1  one-cycle pulse: clear.
- `key_valid`  out  1  one-cycle pulse for every accepted key (debug).
- `key_code`  out  4  code of the last accepted key, held (debug).

## Operation

Key map, by row r and column c (r0..r3 = `row[0]`..`row[3]`, c0..c3 = `col[0]`..`col[3]`):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: F 0 E D

Scanner:
- A column counter drives columns c0→c1→c2→c3 and wraps; each column is low for `SCAN_DIV` cycles.
- Synchronized rows are sampled on the last cycle of each column window.
- One full sweep is 4 column windows. Its result is:
  - NONE: no active row in any column.
  - KEY(code): exactly one row/column intersection active.
  - MULTI: anything else. MULTI is treated as NONE for key acceptance.

Debounce:
- Keep the previous sweep result and a stable counter that saturates at `DEBOUNCE_SWEEPS`.
- If the sweep result equals the previous result, increment the counter; otherwise reset it to 1.
- When the counter reaches `DEBOUNCE_SWEEPS` with KEY and the `reported` flag is clear: accept the key and set `reported`.
- When the counter reaches `DEBOUNCE_SWEEPS` with NONE or MULTI: clear `reported`.
- Holding a key therefore yields exactly one event; there is no auto-repeat.
- A switch from one key to another without a stable release yields no second event.

Phase FSM. States are OP1, OP2, RES. `is_op1` = (state == OP1) and `is_op2` = (state == OP2), both registered.
- OP1:
  - Digit: `is_num` pulse, `num_val` ← digit.
  - C or D: `op_val` ← key, go to OP2.
  - E, A, B: ignored.
- OP2:
  - Digit: `is_num` pulse.
  - C or D: `op_val` updated, stay in OP2.
  - E: `save` pulse, go to RES.
  - A, B: ignored.
- RES:
  - Digit: go to OP1. The digit is discarded and no `is_num` is issued.
  - Other keys: ignored.
- F, from any state: `clr` pulse, go to OP1, `op_val` ← 4'hD.
- `key_valid` and `key_code` update for every accepted key, including ignored ones.

## Timing

Reset values, applied on the first rising edge with `rst` high:
- `col` = 4'b1110; column counter and divider at 0.
- Sweep history = NONE, stable counter = 0, `reported` = 0.
- State = OP1, so `is_op1` = 1 and `is_op2` = 0.
- `is_num`, `save`, `clr`, `key_valid` = 0.
- `num_val` = 0, `op_val` = 4'hD, `key_code` = 0.
- Reset mid-sweep or mid-debounce discards all partial state. A key still held after reset is accepted once it has been stable for `DEBOUNCE_SWEEPS` sweeps.

Cycle-level rules:
- A sweep is 4·`SCAN_DIV` cycles.
- The acceptance decision is made on the cycle that closes a sweep.
- All pulses (`is_num`, `save`, `clr`, `key_valid`) and the held value updates (`num_val`, `op_val`, `key_code`, phase) appear together on the next cycle, for exactly one cycle.
- Latency from a clean press to the pulse is at most (`DEBOUNCE_SWEEPS`+1)·4·`SCAN_DIV` + 3 cycles.
- `num_val` and `op_val` are valid in the same cycle as their pulse.
- At most one event per sweep, so pulses are never back-to-back.

## Test plan

Simulation uses `SCAN_DIV`=4 and `DEBOUNCE_SWEEPS`=2 (sweep = 16 cycles).

1. Reset, no keys: `col` cycles 1110→1101→1011→0111 every 4 cycles; `is_op1`=1, `op_val`=4'hD; no pulses over 200 cycles.
2. Hold '7' (r2/c0) for 100 cycles, then release: exactly one `is_num` pulse with `num_val`=7, arriving within 51 cycles of the press. Re-press after 60 cycles released gives a second pulse.
3. Sequence 1, 2, C, 3, E with releases between: `is_num` ×2 (1, 2) in OP1; `op_val`=4'hC and `is_op2`=1; `is_num` (3); `save` pulse; then `is_op1`=`is_op2`=0 (RES).
4. Bounce: toggle r1/c1 every 3 cycles for 40 cycles, then hold: no event during toggling, exactly one `is_num` with `num_val`=5 after settling.
5. Two keys at once (r0/c0 and r0/c1) held 100 cycles: no event. Releasing c1 leaves '1' stable, giving one `is_num` with `num_val`=1.
6. From OP2 with `op_val`=4'hC, press F: `clr` pulse, `is_op1`=1, `op_val`=4'hD. Asserting `rst` mid-sweep while '9' is held gives reset values, then one '9' event about 2 sweeps later.
